// File: rtl/control_unit_pkg.sv
// Shared definitions for the multi-cycle control unit: opcodes, FSM states,
// write-data source codes and register bank destination codes.
package control_unit_pkg;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_LDI = 3'b001,
        OP_ADD = 3'b010,
        OP_SUB = 3'b011,
        OP_MOV = 3'b100,
        OP_JMP = 3'b101,
        OP_JZ  = 3'b110,
        OP_HLT = 3'b111
    } opcodeT;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } stateT;

    localparam logic [1:0] WR_SEL_IMM  = 2'b00;
    localparam logic [1:0] WR_SEL_ALU  = 2'b01;
    localparam logic [1:0] WR_SEL_REGA = 2'b10;
    localparam logic [1:0] WR_SEL_REGB = 2'b11;

    localparam logic [1:0] RB_DEST_A = 2'b00;
    localparam logic [1:0] RB_DEST_B = 2'b01;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage

// File: rtl/control_unit_decoder.sv
// Combinational instruction decoder: turns the latched instruction word into
// register-write controls and branch/halt qualifiers for the sequencer.
module control_decoder
    import control_unit_pkg::*;
(
    input  logic [7:0] ir,
    output logic       writeEn,
    output logic [1:0] rbDest,
    output logic [1:0] wrSel,
    output logic       aluOp,
    output logic       isJump,
    output logic       isJz,
    output logic       isHalt
);

    opcodeT opcode;

    assign opcode = opcodeT'(ir[7:5]);

    // MOV copies the other register, so its source is the opposite of ir[4]
    always_comb begin
        writeEn = 1'b0;
        rbDest  = ir[4] ? RB_DEST_B : RB_DEST_A;
        wrSel   = WR_SEL_IMM;
        aluOp   = ALU_ADD;
        isJump  = 1'b0;
        isJz    = 1'b0;
        isHalt  = 1'b0;
        case (opcode)
            OP_NOP: ;
            OP_LDI: writeEn = 1'b1;
            OP_ADD: begin
                writeEn = 1'b1;
                wrSel   = WR_SEL_ALU;
                aluOp   = ALU_ADD;
            end
            OP_SUB: begin
                writeEn = 1'b1;
                wrSel   = WR_SEL_ALU;
                aluOp   = ALU_SUB;
            end
            OP_MOV: begin
                writeEn = 1'b1;
                wrSel   = ir[4] ? WR_SEL_REGA : WR_SEL_REGB;
            end
            OP_JMP: isJump = 1'b1;
            OP_JZ:  isJz   = 1'b1;
            OP_HLT: isHalt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle sequencer: fetches over req/ack, decodes, and drives the register
// bank write port and ALU op. Owns the program counter, IR and zero flag.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              instr_req,
    input  logic              instr_ack,
    input  logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] pc_out,
    output logic              rb_write,
    output logic [1:0]        rb_dest,
    output logic [1:0]        wr_sel,
    output logic [DATA_W-1:0] imm_out,
    output logic              alu_op,
    input  logic              wr_data_zero,
    output logic              busy,
    output logic              halted
);

    stateT             state;
    stateT             nextState;
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic              zFlag;
    logic              reqReg;
    logic              rbWriteReg;
    logic [1:0]        rbDestReg;
    logic [1:0]        wrSelReg;
    logic              aluOpReg;
    logic [DATA_W-1:0] immReg;
    logic              ackTaken;
    logic              branchTaken;

    logic              decWriteEn;
    logic [1:0]        decRbDest;
    logic [1:0]        decWrSel;
    logic              decAluOp;
    logic              decIsJump;
    logic              decIsJz;
    logic              decIsHalt;

    control_decoder decoder (
        .ir      (ir[7:0]),
        .writeEn (decWriteEn),
        .rbDest  (decRbDest),
        .wrSel   (decWrSel),
        .aluOp   (decAluOp),
        .isJump  (decIsJump),
        .isJz    (decIsJz),
        .isHalt  (decIsHalt)
    );

    // An ack only counts while our own request is actually out
    assign ackTaken    = instr_ack && reqReg;
    assign branchTaken = decIsJump || (decIsJz && zFlag);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = FETCH;
            HALT:    if (start) nextState = FETCH;
            FETCH:   if (ackTaken) nextState = DECODE;
            DECODE:  nextState = EXEC;
            EXEC:    nextState = decIsHalt ? HALT : FETCH;
            default: nextState = IDLE;
        endcase
    end

    // Request follows the upcoming state so it is a clean flop output;
    // decode results are captured in DECODE and the strobe fires in EXEC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= '0;
            ir         <= '0;
            zFlag      <= 1'b0;
            reqReg     <= 1'b0;
            rbWriteReg <= 1'b0;
            rbDestReg  <= RB_DEST_A;
            wrSelReg   <= WR_SEL_IMM;
            aluOpReg   <= ALU_ADD;
            immReg     <= '0;
        end else begin
            reqReg     <= (nextState == FETCH);
            rbWriteReg <= 1'b0;
            case (state)
                IDLE, HALT: begin
                    if (start) pc <= '0;
                end
                FETCH: begin
                    if (ackTaken) ir <= instr_data;
                end
                DECODE: begin
                    rbWriteReg <= decWriteEn;
                    rbDestReg  <= decRbDest;
                    wrSelReg   <= decWrSel;
                    aluOpReg   <= decAluOp;
                    immReg     <= {{(DATA_W-4){1'b0}}, ir[3:0]};
                end
                EXEC: begin
                    if (rbWriteReg) zFlag <= wr_data_zero;
                    if (branchTaken) begin
                        pc <= ADDR_W'(ir[3:0]);
                    end else if (!decIsHalt) begin
                        pc <= pc + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_req = reqReg;
    assign pc_out    = pc;
    assign rb_write  = rbWriteReg;
    assign rb_dest   = rbDestReg;
    assign wr_sel    = wrSelReg;
    assign alu_op    = aluOpReg;
    assign imm_out   = immReg;
    assign busy      = (state == FETCH) || (state == DECODE) || (state == EXEC);
    assign halted    = (state == HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed self-checking bench for control_unit: serves instructions over the
// req/ack handshake and compares outputs against hand-computed values.
module tb_control_unit;

    logic       clk;
    logic       reset;
    logic       start;
    logic       instr_req;
    logic       instr_ack;
    logic [7:0] instr_data;
    logic [3:0] pc_out;
    logic       rb_write;
    logic [1:0] rb_dest;
    logic [1:0] wr_sel;
    logic [7:0] imm_out;
    logic       alu_op;
    logic       wr_data_zero;
    logic       busy;
    logic       halted;

    int testsRun;
    int testsFailed;

    int         obsReqCycles;
    int         obsWrites;
    logic [1:0] obsDest;
    logic [1:0] obsSel;
    logic       obsAlu;
    logic [7:0] obsImm;

    control_unit #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .instr_req    (instr_req),
        .instr_ack    (instr_ack),
        .instr_data   (instr_data),
        .pc_out       (pc_out),
        .rb_write     (rb_write),
        .rb_dest      (rb_dest),
        .wr_sel       (wr_sel),
        .imm_out      (imm_out),
        .alu_op       (alu_op),
        .wr_data_zero (wr_data_zero),
        .busy         (busy),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic sampleCycle();
        if (instr_req) obsReqCycles++;
        if (rb_write) obsWrites++;
    endtask

    // Entered one step after the edge that put the DUT in FETCH; returns one
    // step after the edge that ends EXEC.
    task automatic applyStimulus(input logic [7:0] word, input int ackDelay,
                                 input logic zIn, input logic startWithAck);
        obsReqCycles = 0;
        obsWrites    = 0;
        for (int i = 0; i < ackDelay; i++) begin
            sampleCycle();
            tick();
        end
        instr_ack  = 1'b1;
        instr_data = word;
        start      = startWithAck;
        sampleCycle();
        tick();
        instr_ack  = 1'b0;
        instr_data = 8'h00;
        start      = 1'b0;
        sampleCycle();
        tick();
        sampleCycle();
        obsDest = rb_dest;
        obsSel  = wr_sel;
        obsAlu  = alu_op;
        obsImm  = imm_out;
        wr_data_zero = zIn;
        tick();
        wr_data_zero = 1'b0;
    endtask

    initial begin
        testsRun     = 0;
        testsFailed  = 0;
        reset        = 1'b1;
        start        = 1'b0;
        instr_ack    = 1'b0;
        instr_data   = 8'h00;
        wr_data_zero = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pc", pc_out, 4'd0);
        checkOutput("rst_req", instr_req, 1'b0);
        checkOutput("rst_write", rb_write, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_halted", halted, 1'b0);
        checkOutput("rst_ctrl", {rb_dest, wr_sel, alu_op, imm_out}, 13'd0);

        reset = 1'b0;
        tick();
        checkOutput("idle_req", instr_req, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("start_req", instr_req, 1'b1);
        checkOutput("start_busy", busy, 1'b1);
        checkOutput("start_pc", pc_out, 4'd0);

        applyStimulus(8'h25, 0, 1'b0, 1'b0);
        checkOutput("ldiA_writes", obsWrites, 1);
        checkOutput("ldiA_ctrl", {obsSel, obsDest}, {2'b00, 2'b00});
        checkOutput("ldiA_imm", obsImm, 8'h05);
        checkOutput("ldiA_pc", pc_out, 4'd1);
        checkOutput("ldiA_strobe_done", rb_write, 1'b0);

        applyStimulus(8'h33, 0, 1'b0, 1'b0);
        checkOutput("ldiB_ctrl", {obsSel, obsDest}, {2'b00, 2'b01});
        checkOutput("ldiB_imm", obsImm, 8'h03);
        checkOutput("ldiB_pc", pc_out, 4'd2);

        applyStimulus(8'h40, 0, 1'b0, 1'b0);
        checkOutput("addA_writes", obsWrites, 1);
        checkOutput("addA_ctrl", {obsSel, obsDest, obsAlu}, {2'b01, 2'b00, 1'b0});
        checkOutput("addA_pc", pc_out, 4'd3);

        applyStimulus(8'hE0, 0, 1'b0, 1'b0);
        checkOutput("hlt_writes", obsWrites, 0);
        checkOutput("hlt_halted", halted, 1'b1);
        checkOutput("hlt_busy", busy, 1'b0);
        checkOutput("hlt_pc", pc_out, 4'd3);
        tick();
        checkOutput("hlt_req", instr_req, 1'b0);

        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("restart_halted", halted, 1'b0);
        checkOutput("restart_pc", pc_out, 4'd0);
        checkOutput("restart_req", instr_req, 1'b1);

        applyStimulus(8'h70, 0, 1'b1, 1'b0);
        checkOutput("subB_ctrl", {obsSel, obsDest, obsAlu}, {2'b01, 2'b01, 1'b1});
        checkOutput("subB_pc", pc_out, 4'd1);
        applyStimulus(8'hCA, 0, 1'b0, 1'b0);
        checkOutput("jz_taken_writes", obsWrites, 0);
        checkOutput("jz_taken_pc", pc_out, 4'd10);

        applyStimulus(8'h70, 0, 1'b0, 1'b0);
        checkOutput("subB_nz_pc", pc_out, 4'd11);
        applyStimulus(8'hCA, 0, 1'b0, 1'b0);
        checkOutput("jz_not_taken_pc", pc_out, 4'd12);

        applyStimulus(8'h27, 4, 1'b0, 1'b0);
        checkOutput("delay_req_cycles", obsReqCycles, 5);
        checkOutput("delay_writes", obsWrites, 1);
        checkOutput("delay_imm", obsImm, 8'h07);
        checkOutput("delay_pc", pc_out, 4'd13);
        checkOutput("delay_refetch_req", instr_req, 1'b1);

        applyStimulus(8'h90, 0, 1'b0, 1'b0);
        checkOutput("movB_ctrl", {obsSel, obsDest}, {2'b10, 2'b01});
        checkOutput("movB_pc", pc_out, 4'd14);

        applyStimulus(8'h00, 0, 1'b0, 1'b0);
        checkOutput("nop14_writes", obsWrites, 0);
        checkOutput("nop14_pc", pc_out, 4'd15);
        applyStimulus(8'h00, 0, 1'b0, 1'b0);
        checkOutput("nop15_writes", obsWrites, 0);
        checkOutput("wrap_pc", pc_out, 4'd0);

        applyStimulus(8'hA9, 0, 1'b0, 1'b1);
        checkOutput("jmp_start_ignored_pc", pc_out, 4'd9);

        applyStimulus(8'h70, 0, 1'b1, 1'b0);
        applyStimulus(8'h00, 0, 1'b0, 1'b0);
        checkOutput("z_hold_nop_pc", pc_out, 4'd11);
        applyStimulus(8'hC5, 0, 1'b0, 1'b0);
        checkOutput("z_hold_jz_pc", pc_out, 4'd5);
        applyStimulus(8'h80, 0, 1'b0, 1'b0);
        checkOutput("movA_ctrl", {obsSel, obsDest}, {2'b11, 2'b00});
        checkOutput("movA_pc", pc_out, 4'd6);

        checkOutput("pre_rst_req", instr_req, 1'b1);
        instr_ack  = 1'b1;
        instr_data = 8'h25;
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midrst_req", instr_req, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_pc", pc_out, 4'd0);
        checkOutput("midrst_imm", imm_out, 8'h00);
        checkOutput("midrst_ctrl", {rb_write, rb_dest, wr_sel, alu_op, halted}, 7'd0);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("postrst_ack_ignored_busy", busy, 1'b0);
        checkOutput("postrst_ack_ignored_req", instr_req, 1'b0);
        instr_ack  = 1'b0;
        instr_data = 8'h00;

        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("rst_restart_pc", pc_out, 4'd0);
        checkOutput("rst_restart_req", instr_req, 1'b1);
        applyStimulus(8'h3F, 0, 1'b0, 1'b0);
        checkOutput("ldiB15_ctrl", {obsSel, obsDest}, {2'b00, 2'b01});
        checkOutput("ldiB15_imm", obsImm, 8'h0F);
        applyStimulus(8'hE0, 0, 1'b0, 1'b0);
        checkOutput("final_halted", halted, 1'b1);
        checkOutput("final_pc", pc_out, 4'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multi-cycle sequencer for the 8-bit datapath: fetches 8-bit instructions from a 16-word program memory over a req/ack handshake, decodes them, and drives the register bank write port (write strobe, destination select, write-data source select) and ALU operation. It owns the program counter and zero flag and sits between program memory and the register bank/ALU pair.

## Interface
Parameters:
- ADDR_W, 4, program counter / program memory address width
- DATA_W, 8, instruction and immediate width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  one-cycle pulse; leaves IDLE/HALT and begins at PC 0
- instr_req  out  1  held high while requesting instruction at pc_out
- instr_ack  in  1  memory returns instr_data this cycle
- instr_data  in  8  instruction word, valid when instr_ack=1
- pc_out  out  ADDR_W  current program counter
- rb_write  out  1  register bank write strobe, one cycle
- rb_dest  out  2  00=A, 01=B (10/11 never driven)
- wr_sel  out  2  write-data source: 00=imm, 01=ALU, 10=regA, 11=regB
- imm_out  out  8  zero-extended immediate {4'b0, instr[3:0]}
- alu_op  out  1  0=add (A+B), 1=sub (A-B)
- wr_data_zero  in  1  datapath flag: selected write data == 0
- busy  out  1  high in FETCH/DECODE/EXEC
- halted  out  1  high in HALT

## Operation
- Instruction: [7:5] opcode, [4] dest (0=A, 1=B), [3:0] imm/target.
- Opcodes: 000 NOP; 001 LDI dest<=imm; 010 ADD dest<=A+B; 011 SUB dest<=A-B; 100 MOV dest<=other register; 101 JMP pc<=target; 110 JZ pc<=target if Z=1; 111 HLT.
- States: IDLE -> (start) FETCH -> (instr_ack) DECODE -> EXEC -> FETCH; EXEC with HLT -> HALT; HALT -> (start) FETCH with pc=0. start ignored in FETCH/DECODE/EXEC.
- FETCH: instr_req=1 every cycle until instr_ack; instruction latched into IR on ack cycle; req drops the following cycle.
- DECODE: registers control outputs from IR; no strobes.
- EXEC: rb_write=1 for exactly one cycle for LDI/ADD/SUB/MOV; rb_dest={1'b0, IR[4]}; wr_sel per opcode (MOV dest A selects 11, dest B selects 10); Z<=wr_data_zero on same edge. JMP/JZ-taken load pc<=IR[3:0]; all others pc<=pc+1, wrapping 15->0. JZ not taken and NOP: pc+1 only. HLT: pc unchanged.
- Z updated only by register writes; JMP/JZ/NOP/HLT leave it.
- rb_write, wr_sel, rb_dest, alu_op meaningful only while rb_write=1; otherwise rb_write=0, others hold last decode.

## Timing
- Reset values: state IDLE, pc_out 0, IR 0, Z 0, instr_req 0, rb_write 0, rb_dest 00, wr_sel 00, imm_out 0, alu_op 0, busy 0, halted 0.
- Instruction latency: (ack wait) + 3 cycles; with ack in first FETCH cycle, one instruction per 3 cycles.
- instr_req is registered; instr_ack while instr_req=0 is ignored.
- Reset asserted mid-FETCH: instr_req drops asynchronously; pending ack ignored after release.
- start and instr_ack in same cycle in FETCH: ack honored, start ignored.
- Write strobe and zero-flag update coincide with the EXEC rising edge; register bank sees data on that edge.

## Structure
- Shared package: opcode constants, state encoding (IDLE, FETCH, DECODE, EXEC, HALT), wr_sel codes, rb_dest codes.
- One sub-module natural: control_decoder (combinational IR -> write enable, rb_dest, wr_sel, alu_op, is_jump, is_jz, is_halt), instantiated by control_unit which holds FSM, PC, IR, Z.

## Test plan
- Reset then start; program LDI A,5 (0x25); LDI B,3 (0x33); ADD A (0x40); HLT -> rb_write pulses with wr_sel 00/00/01, rb_dest 00/01/00; halted=1, pc_out=3.
- SUB B with wr_data_zero=1 then JZ 0xA (0xCA) -> Z=1, pc_out=10 after EXEC; repeat with wr_data_zero=0 -> pc_out advances by 1.
- instr_ack delayed 4 cycles -> instr_req high exactly 5 cycles, one rb_write per instruction, no duplicate fetch.
- PC wrap: NOPs from pc 14 -> pc_out 15 then 0, no strobes.
- Reset asserted during FETCH with req high -> instr_req, busy fall immediately, all outputs at reset values; start restarts at pc 0.
- HALT then start pulse -> FETCH of address 0, halted=0; MOV B (0x90) -> wr_sel 10, rb_dest 01.
